led_pattern_sequencer: RTL and testbench

- Controller that sequences the 8-bit LED output register through four display patterns.
- A rising edge on `switch` selects the next pattern.
- A prescaler sets the pattern step rate; `enable` freezes the whole sequence.
- Sits between the board switch input and the LED bank, replacing the constant-zero LED driver.

---
 rtl/led_pattern_sequencer.sv | 121 ++++++++++++
 tb/tb_led_pattern_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: steps an 8-bit LED register through RUN, BOUNCE, COUNT and BLINK
// patterns at a prescaled rate; a rising edge on switch advances to the next pattern.
module led_pattern_sequencer #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       switch,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  typedef enum logic [1:0] {
    ModeRun    = 2'd0,
    ModeBounce = 2'd1,
    ModeCount  = 2'd2,
    ModeBlink  = 2'd3
  } mode_e;

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

  logic              sw_q;
  logic [PrescW-1:0] presc_q;
  mode_e             mode_q;
  logic [7:0]        led_q;
  logic              dir_right_q;
  logic              tick_q;

  logic sw_rise;
  logic step_now;
  logic led_onehot;

  assign sw_rise    = switch & ~sw_q & enable;
  assign step_now   = enable & (presc_q == PrescMax);
  assign led_onehot = (led_q != 8'h00) && ((led_q & (led_q - 8'h01)) == 8'h00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_q        <= 1'b0;
      presc_q     <= '0;
      mode_q      <= ModeRun;
      led_q       <= 8'h01;
      dir_right_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      sw_q <= switch;
      if (!enable) begin
        tick_q <= 1'b0;
      end else if (sw_rise) begin
        // A mode change overrides any step due this cycle and restarts the step phase.
        presc_q     <= '0;
        tick_q      <= 1'b0;
        dir_right_q <= 1'b0;
        unique case (mode_q)
          ModeRun: begin
            mode_q <= ModeBounce;
            led_q  <= 8'h01;
          end
          ModeBounce: begin
            mode_q <= ModeCount;
            led_q  <= 8'h00;
          end
          ModeCount: begin
            mode_q <= ModeBlink;
            led_q  <= 8'hFF;
          end
          ModeBlink: begin
            mode_q <= ModeRun;
            led_q  <= 8'h01;
          end
          default: begin
            mode_q <= ModeRun;
            led_q  <= 8'h01;
          end
        endcase
      end else begin
        tick_q  <= step_now;
        presc_q <= step_now ? '0 : presc_q + PrescW'(1);
        if (step_now) begin
          unique case (mode_q)
            ModeRun: led_q <= {led_q[6:0], led_q[7]};
            ModeBounce: begin
              if (!led_onehot) begin
                led_q       <= 8'h01;
                dir_right_q <= 1'b0;
              end else if (!dir_right_q) begin
                // Turn around as the end LED is reached so each end shows exactly once.
                if (led_q[7]) begin
                  led_q       <= led_q >> 1;
                  dir_right_q <= 1'b1;
                end else begin
                  led_q <= led_q << 1;
                  if (led_q[6]) dir_right_q <= 1'b1;
                end
              end else begin
                if (led_q[0]) begin
                  led_q       <= led_q << 1;
                  dir_right_q <= 1'b0;
                end else begin
                  led_q <= led_q >> 1;
                  if (led_q[1]) dir_right_q <= 1'b0;
                end
              end
            end
            ModeCount: led_q <= led_q + 8'd1;
            ModeBlink: led_q <= ~led_q;
            default:   led_q <= 8'h01;
          endcase
        end
      end
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: two instances (TICK_DIV=1 and 4) share stimulus;
// each queued expectation names the instance it applies to.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       switch;
  logic [7:0] led1, led4;
  logic [1:0] mode1, mode4;
  logic       tick1, tick4;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.TICK_DIV(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .switch (switch),
    .led    (led1),
    .mode   (mode1),
    .tick   (tick1)
  );

  led_pattern_sequencer #(.TICK_DIV(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .switch (switch),
    .led    (led4),
    .mode   (mode4),
    .tick   (tick4)
  );

  typedef struct {
    int         id;
    int         sel;
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   next_id  = 0;
  event async_chk;

  task automatic compare(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic pop_check();
    exp_t       e;
    logic [7:0] l;
    logic [1:0] m;
    logic       t;
    if (exp_q.size() == 0) begin
      compare("queue_underflow", 0, 1);
    end else begin
      e = exp_q.pop_front();
      l = (e.sel == 1) ? led1 : led4;
      m = (e.sel == 1) ? mode1 : mode4;
      t = (e.sel == 1) ? tick1 : tick4;
      compare($sformatf("v%0d_dut%0d_led", e.id, e.sel), int'(l), int'(e.led));
      compare($sformatf("v%0d_dut%0d_mode", e.id, e.sel), int'(m), int'(e.mode));
      compare($sformatf("v%0d_dut%0d_tick", e.id, e.sel), int'(t), int'(e.tick));
    end
  endtask

  // Monitor: outputs presented after each rising edge are checked 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) pop_check();
  end

  always @(async_chk) pop_check();

  task automatic push(input int sel, input logic [7:0] l, input logic [1:0] m, input logic t);
    exp_t e;
    e.id   = next_id;
    e.sel  = sel;
    e.led  = l;
    e.mode = m;
    e.tick = t;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic e, input logic s, input int sel,
                      input logic [7:0] l, input logic [1:0] m, input logic t);
    @(negedge clk);
    rst    = r;
    enable = e;
    switch = s;
    push(sel, l, m, t);
  endtask

  logic [7:0] bseq [16];
  logic [7:0] r;

  initial begin
    bseq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    rst    = 1'b1;
    enable = 1'b0;
    switch = 1'b0;
    #2 rst = 1'b0;

    // Reset state
    step(0, 0, 0, 1, 8'h01, 2'd0, 1'b0);
    step(0, 0, 0, 4, 8'h01, 2'd0, 1'b0);

    // RUN, TICK_DIV=1: rotate every cycle, 11 steps lands on 08
    r = 8'h01;
    for (int k = 1; k <= 11; k++) begin
      r = {r[6:0], r[7]};
      step(1, 1, 0, 1, r, 2'd0, 1'b1);
    end
    step(1, 1, 1, 1, 8'h01, 2'd1, 1'b0);
    for (int i = 0; i < 16; i++) step(1, 1, (i < 15), 1, bseq[i], 2'd1, 1'b1);

    // COUNT through the wrap
    step(1, 1, 1, 1, 8'h00, 2'd2, 1'b0);
    for (int k = 1; k <= 257; k++) step(1, 1, 1, 1, 8'(k), 2'd2, 1'b1);
    step(1, 1, 0, 1, 8'h02, 2'd2, 1'b1);

    // BLINK then back to RUN
    step(1, 1, 1, 1, 8'hFF, 2'd3, 1'b0);
    step(1, 1, 1, 1, 8'h00, 2'd3, 1'b1);
    step(1, 1, 1, 1, 8'hFF, 2'd3, 1'b1);
    step(1, 1, 1, 1, 8'h00, 2'd3, 1'b1);
    step(1, 1, 0, 1, 8'hFF, 2'd3, 1'b1);
    step(1, 1, 1, 1, 8'h01, 2'd0, 1'b0);
    step(1, 1, 1, 1, 8'h02, 2'd0, 1'b1);

    // TICK_DIV=4: reach COUNT, step every 4th enabled cycle
    step(0, 0, 0, 4, 8'h01, 2'd0, 1'b0);
    step(1, 1, 1, 4, 8'h01, 2'd1, 1'b0);
    step(1, 1, 0, 4, 8'h01, 2'd1, 1'b0);
    step(1, 1, 1, 4, 8'h00, 2'd2, 1'b0);
    for (int i = 1; i <= 20; i++) step(1, 1, 1, 4, 8'(i / 4), 2'd2, (i % 4 == 0));
    step(1, 1, 0, 4, 8'h05, 2'd2, 1'b0);
    // Freeze; the switch rise while disabled must be discarded
    step(1, 0, 0, 4, 8'h05, 2'd2, 1'b0);
    step(1, 0, 1, 4, 8'h05, 2'd2, 1'b0);
    step(1, 0, 1, 4, 8'h05, 2'd2, 1'b0);
    step(1, 1, 1, 4, 8'h05, 2'd2, 1'b0);
    step(1, 1, 1, 4, 8'h05, 2'd2, 1'b0);
    step(1, 1, 1, 4, 8'h06, 2'd2, 1'b1);
    // Switch edge coincides with a due step: edge wins
    step(1, 1, 0, 4, 8'h06, 2'd2, 1'b0);
    step(1, 1, 0, 4, 8'h06, 2'd2, 1'b0);
    step(1, 1, 0, 4, 8'h06, 2'd2, 1'b0);
    step(1, 1, 1, 4, 8'hFF, 2'd3, 1'b0);
    step(1, 1, 1, 4, 8'hFF, 2'd3, 1'b0);
    step(1, 1, 1, 4, 8'hFF, 2'd3, 1'b0);
    step(1, 1, 1, 4, 8'hFF, 2'd3, 1'b0);
    step(1, 1, 1, 4, 8'h00, 2'd3, 1'b1);

    // Async reset mid-cycle in BOUNCE moving right at 10
    step(0, 0, 0, 1, 8'h01, 2'd0, 1'b0);
    step(1, 1, 1, 1, 8'h01, 2'd1, 1'b0);
    for (int i = 0; i < 10; i++) step(1, 1, 1, 1, bseq[i], 2'd1, 1'b1);
    @(posedge clk);
    #3;
    rst    = 1'b0;
    switch = 1'b0;
    #1;
    push(1, 8'h01, 2'd0, 1'b0);
    ->async_chk;
    step(0, 0, 0, 1, 8'h01, 2'd0, 1'b0);
    step(1, 1, 0, 1, 8'h02, 2'd0, 1'b1);
    step(1, 1, 0, 1, 8'h04, 2'd0, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    compare("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
